// File: rtl/divider.sv
// 32-bit radix-2 restoring divider with signed/unsigned modes, fixed 33-cycle latency.
// Results are registered and held until the next completed division or reset.
module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    logic [31:0] m;
    if (is_signed && v[31]) begin
      m = neg32(v);
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_t      state_r, state_s;
  logic [5:0]  count_r, count_s;
  logic [32:0] rem_r, rem_s;
  logic [31:0] quo_r, quo_s;
  logic [31:0] dvs_r, dvs_s;
  logic [31:0] dvd_r, dvd_s;
  logic        sign_r, sign_s;
  logic        dvs_neg_r, dvs_neg_s;
  logic        dz_r, dz_s;
  logic [31:0] q_r, q_s;
  logic [31:0] r_r, r_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [33:0] shifted_s;
  logic [33:0] trial_s;
  logic        neg_q_s;
  logic        neg_r_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == 6'd31) begin
          state_s = FINISH;
        end else begin
          state_s = CALC;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath next values: operand capture, one restoring step per CALC cycle, sign fix-up
  always_comb begin
    count_s   = count_r;
    rem_s     = rem_r;
    quo_s     = quo_r;
    dvs_s     = dvs_r;
    dvd_s     = dvd_r;
    sign_s    = sign_r;
    dvs_neg_s = dvs_neg_r;
    dz_s      = dz_r;
    q_s       = q_r;
    r_s       = r_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    // one extra top bit keeps the borrow of the 33-bit trial subtraction
    shifted_s = {rem_r, quo_r[31]};
    trial_s   = shifted_s - {2'b00, dvs_r};
    neg_q_s   = sign_r & (dvd_r[31] ^ dvs_neg_r);
    neg_r_s   = sign_r & dvd_r[31];
    case (state_r)
      IDLE: begin
        if (start) begin
          count_s   = 6'd0;
          rem_s     = 33'd0;
          quo_s     = mag32(dividend, sign);
          dvs_s     = mag32(divisor, sign);
          dvd_s     = dividend;
          sign_s    = sign;
          dvs_neg_s = divisor[31];
          dz_s      = (divisor == 32'd0);
          busy_s    = 1'b1;
        end else begin
          busy_s    = 1'b0;
        end
      end
      CALC: begin
        count_s = count_r + 6'd1;
        if (trial_s[33] == 1'b0) begin
          rem_s = trial_s[32:0];
          quo_s = {quo_r[30:0], 1'b1};
        end else begin
          rem_s = shifted_s[32:0];
          quo_s = {quo_r[30:0], 1'b0};
        end
      end
      FINISH: begin
        if (dz_r) begin
          q_s = 32'hFFFF_FFFF;
          r_s = dvd_r;
        end else begin
          q_s = neg_q_s ? neg32(quo_r) : quo_r;
          r_s = neg_r_s ? neg32(rem_r[31:0]) : rem_r[31:0];
        end
        done_s = 1'b1;
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r   <= 6'd0;
      rem_r     <= 33'd0;
      quo_r     <= 32'd0;
      dvs_r     <= 32'd0;
      dvd_r     <= 32'd0;
      sign_r    <= 1'b0;
      dvs_neg_r <= 1'b0;
      dz_r      <= 1'b0;
      q_r       <= 32'd0;
      r_r       <= 32'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      count_r   <= count_s;
      rem_r     <= rem_s;
      quo_r     <= quo_s;
      dvs_r     <= dvs_s;
      dvd_r     <= dvd_s;
      sign_r    <= sign_s;
      dvs_neg_r <= dvs_neg_s;
      dz_r      <= dz_s;
      q_r       <= q_s;
      r_r       <= r_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign q    = q_r;
  assign r    = r_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus randomized divisions,
// checked every cycle against an arithmetic reference model with a countdown timer.
`timescale 1ns/1ps
module tb_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  divider dut (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor),
    .q(q), .r(r), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic: {quotient, remainder}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, qq, rr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    qq = sa / sb;
    rr = sa % sb;
    return {qq[31:0], rr[31:0]};
  endfunction

  // Model: a request accepted when idle produces its result 33 edges later
  logic [31:0] m_q = 32'd0, m_r = 32'd0, p_q = 32'd0, p_r = 32'd0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= 32'd0; m_r <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_q <= p_q; m_r <= p_r; m_done <= 1'b1; m_busy <= 1'b0;
        end
      end else if (start) begin
        {p_q, p_r} <= ref_div(dividend, divisor, sign);
        m_cnt  <= 33;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("q", q, m_q);
      check("r", r, m_r);
      if (done === 1'b1) done_seen++;
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input bit noise,
                         output logic [31:0] oq, output logic [31:0] orr, output int lat);
    sign = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (noise && k == 7) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom; sign = ~s;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    oq = q; orr = r;
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no done within 40 cycles for 0x%08h / 0x%08h", a, b);
    end
  endtask

  task automatic dir(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] eq, input logic [31:0] er);
    logic [31:0] oq, orr;
    int lat;
    run_div(a, b, s, 1'b0, oq, orr, lat);
    check({name, " q"}, oq, eq);
    check({name, " r"}, orr, er);
    check({name, " latency"}, lat, 32'd33);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    logic [31:0] oq, orr, a, b;
    logic        s;
    int lat, base;

    v = ref_div(32'd100, 32'd7, 1'b0);
    check("model 100/7 q", v[63:32], 32'h0000_000E);
    check("model 100/7 r", v[31:0], 32'd2);
    v = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("model -7/2 q", v[63:32], 32'hFFFF_FFFD);
    check("model -7/2 r", v[31:0], 32'hFFFF_FFFF);
    v = ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("model ovf q", v[63:32], 32'h8000_0000);
    check("model ovf r", v[31:0], 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("reset q", q, 32'd0);
    check("reset r", r, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    dir("u 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    dir("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    dir("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    dir("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    dir("u max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    dir("s -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    dir("u 5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);

    // Second start while busy must be ignored
    repeat (2) @(posedge clk);
    #1;
    base = done_seen;
    sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    dividend = 32'd1000; divisor = 32'd3; sign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    check("busy-start q", q, 32'd14);
    check("busy-start r", r, 32'd2);
    check("busy-start done count", done_seen - base, 32'd1);

    // Reset in the middle of a division
    base = done_seen;
    sign = 1'b0; dividend = 32'd123456; divisor = 32'd789; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort q", q, 32'd0);
    check("abort r", r, 32'd0);
    #1;
    reset = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    check("abort done count", done_seen - base, 32'd0);
    dir("u 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      run_div(a, b, s, ($urandom_range(0, 3) == 0), oq, orr, lat);
      v = ref_div(a, b, s);
      check("rand q", oq, v[63:32]);
      check("rand r", orr, v[31:0]);
      check("rand latency", lat, 32'd33);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
